o_buf_controller: RTL and testbench

- Downstream consumer of the input linebuffer controller.
- After each completed line (line_valid pulse), it reads the line's 32-bit words back from the dual-bank linebuffer and unpacks each word into four 8-bit pixels.
- It presents those pixels as a valid/ready stream to the processing pipeline.
- It tracks the bank ping-pong and frame boundaries, and flags lines that arrive while two lines are already pending.

---
 rtl/o_buf_controller.sv | 182 ++++++++++++++++++
 tb/tb_o_buf_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/o_buf_controller.sv
// Linebuffer read-back controller: fetches each completed line word by word and streams it
// out as 8-bit pixels on a valid/ready interface, tracking bank ping-pong and frame starts.
module o_buf_controller #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned LINE_WORDS    = 160
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     line_valid,
  input  logic                     frame_valid,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH:0]   addr,
  input  logic [31:0]              rd_data,
  output logic [7:0]               o_pixel,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sol,
  output logic                     o_eol,
  output logic                     o_sof,
  output logic                     overflow
);

  typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

  localparam logic [ADDRESS_WIDTH-1:0] LastWord = ADDRESS_WIDTH'(LINE_WORDS - 1);

  state_e                   state_q, state_d;
  logic [1:0]               pending_q, pending_d;
  logic                     bank_q, bank_d;
  logic                     sof_pending_q, sof_pending_d;
  logic                     frame_req_q, frame_req_d;
  logic                     overflow_q, overflow_d;
  logic                     nxt_full_q, nxt_full_d;
  logic                     rd_inflight_q, rd_inflight_d;
  logic [31:0]              cur_word_q, cur_word_d;
  logic [31:0]              nxt_word_q, nxt_word_d;
  logic [1:0]               byte_q, byte_d;
  logic [ADDRESS_WIDTH-1:0] word_q, word_d;

  logic accept, first_pix, last_pix, line_done, apply_frame, bank_eff;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= 2'd0;
      bank_q        <= 1'b0;
      sof_pending_q <= 1'b1;
      frame_req_q   <= 1'b0;
      overflow_q    <= 1'b0;
      nxt_full_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
      cur_word_q    <= '0;
      nxt_word_q    <= '0;
      byte_q        <= 2'd0;
      word_q        <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      bank_q        <= bank_d;
      sof_pending_q <= sof_pending_d;
      frame_req_q   <= frame_req_d;
      overflow_q    <= overflow_d;
      nxt_full_q    <= nxt_full_d;
      rd_inflight_q <= rd_inflight_d;
      cur_word_q    <= cur_word_d;
      nxt_word_q    <= nxt_word_d;
      byte_q        <= byte_d;
      word_q        <= word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    bank_d        = bank_q;
    sof_pending_d = sof_pending_q;
    frame_req_d   = frame_req_q;
    overflow_d    = overflow_q;
    nxt_full_d    = nxt_full_q;
    rd_inflight_d = 1'b0;
    cur_word_d    = cur_word_q;
    nxt_word_d    = nxt_word_q;
    byte_d        = byte_q;
    word_d        = word_q;
    rd_en         = 1'b0;
    addr          = '0;
    apply_frame   = 1'b0;
    bank_eff      = bank_q;

    o_valid   = (state_q == StStream);
    accept    = o_valid & i_ready;
    first_pix = (word_q == '0) && (byte_q == 2'd0);
    last_pix  = (word_q == LastWord) && (byte_q == 2'd3);
    line_done = accept & last_pix;

    unique case (byte_q)
      2'd0:    o_pixel = cur_word_q[7:0];
      2'd1:    o_pixel = cur_word_q[15:8];
      2'd2:    o_pixel = cur_word_q[23:16];
      default: o_pixel = cur_word_q[31:24];
    endcase
    if (!o_valid) o_pixel = 8'd0;
    o_sol = o_valid & first_pix;
    o_eol = o_valid & last_pix;
    o_sof = o_valid & first_pix & sof_pending_q;

    if (line_valid && !line_done) begin
      if (pending_q == 2'd2) overflow_d = 1'b1;
      else                   pending_d  = pending_q + 2'd1;
    end else if (!line_valid && line_done) begin
      pending_d = pending_q - 2'd1;
    end

    // Outside a line the frame reset applies at once; inside one it waits for line end.
    if (frame_valid) begin
      if (state_q == StIdle) begin
        bank_d        = 1'b0;
        sof_pending_d = 1'b1;
      end else begin
        frame_req_d = 1'b1;
      end
    end

    if (rd_inflight_q) begin
      nxt_word_d = rd_data;
      nxt_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q != 2'd0) begin
          bank_eff = frame_valid ? 1'b0 : bank_q;
          rd_en    = 1'b1;
          addr     = {bank_eff, {ADDRESS_WIDTH{1'b0}}};
          state_d  = StFetch;
        end
      end
      StFetch: begin
        cur_word_d = rd_data;
        byte_d     = 2'd0;
        word_d     = '0;
        nxt_full_d = 1'b0;
        state_d    = StStream;
      end
      default: begin
        if (line_done) begin
          apply_frame = frame_req_q | frame_valid;
          bank_eff    = apply_frame ? 1'b0 : ~bank_q;
          bank_d      = bank_eff;
          frame_req_d = 1'b0;
          if (apply_frame) sof_pending_d = 1'b1;
          if (pending_d != 2'd0) begin
            rd_en   = 1'b1;
            addr    = {bank_eff, {ADDRESS_WIDTH{1'b0}}};
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end else if (accept) begin
          if (first_pix) sof_pending_d = 1'b0;
          if (byte_q == 2'd3) begin
            cur_word_d = nxt_word_q;
            nxt_full_d = 1'b0;
            word_d     = word_q + ADDRESS_WIDTH'(1);
            byte_d     = 2'd0;
          end else begin
            byte_d = byte_q + 2'd1;
          end
          // Prefetch on byte 1 so the next word lands before byte 3 leaves.
          if ((byte_q == 2'd1) && (word_q != LastWord) && !nxt_full_q) begin
            rd_en         = 1'b1;
            addr          = {bank_q, word_q + ADDRESS_WIDTH'(1)};
            rd_inflight_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_o_buf_controller.sv
// Bench for o_buf_controller with a 4-word line: cycle table for one line, scoreboard
// of expected pixels/read addresses for the stall, back-to-back, overflow, frame and reset cases.
module tb_o_buf_controller;
  localparam int unsigned AW = 2;
  localparam int unsigned LW = 4;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          line_valid = 1'b0;
  logic          frame_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          rd_en;
  logic [AW:0]   addr;
  logic [31:0]   rd_data = '0;
  logic [7:0]    o_pixel;
  logic          o_valid, o_sol, o_eol, o_sof, overflow;

  o_buf_controller #(.ADDRESS_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .pclk(pclk), .reset(reset), .line_valid(line_valid), .frame_valid(frame_valid),
    .rd_en(rd_en), .addr(addr), .rd_data(rd_data), .o_pixel(o_pixel), .o_valid(o_valid),
    .i_ready(i_ready), .o_sol(o_sol), .o_eol(o_eol), .o_sof(o_sof), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  logic [31:0] mem [8];
  always @(posedge pclk) if (rd_en) rd_data <= mem[addr];

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] pix;
    logic       sol;
    logic       eol;
    logic       sof;
  } px_t;

  px_t         px_q[$];
  logic [AW:0] ad_q[$];
  int          rd_count = 0;
  int          acc_count = 0;
  int          acc_cyc [32];
  logic        toggle = 1'b0;

  task automatic push_line(input logic bank, input logic sof);
    for (int p = 0; p < 4 * LW; p++) begin
      px_q.push_back({8'(16 * int'(bank) + p), p == 0, p == 4 * LW - 1, sof && (p == 0)});
    end
    for (int w = 0; w < LW; w++) ad_q.push_back({bank, 2'(w)});
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_lv();
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    px_q.delete();
    ad_q.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((px_q.size() != 0 || ad_q.size() != 0) && n < budget) begin
      tick();
      if (toggle) i_ready = ~i_ready;
      n++;
    end
    chk({name, "_drained"}, 32'(px_q.size() + ad_q.size()), 32'd0);
    repeat (4) begin
      tick();
      if (toggle) i_ready = ~i_ready;
    end
  endtask

  // Scoreboard monitor: compares every read address and accepted pixel against the queues.
  logic        stall_prev = 1'b0;
  logic [11:0] prev_out = '0;
  px_t         e;
  initial begin
    forever begin
      @(negedge pclk);
      if (reset) begin
        stall_prev = 1'b0;
        continue;
      end
      if (rd_en) begin
        rd_count++;
        if (ad_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got addr 0x%0h, expected no read", addr);
        end else begin
          chk("rd_addr", 32'(addr), 32'(ad_q.pop_front()));
        end
      end
      if (o_valid && i_ready) begin
        if (px_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL px_unexpected: got pixel 0x%0h, expected none", o_pixel);
        end else begin
          e = px_q.pop_front();
          chk("pixel", 32'(o_pixel), 32'(e.pix));
          chk("sol", 32'(o_sol), 32'(e.sol));
          chk("eol", 32'(o_eol), 32'(e.eol));
          chk("sof", 32'(o_sof), 32'(e.sof));
        end
        if (int'(o_pixel) < 32) acc_cyc[int'(o_pixel)] = cyc;
        acc_count++;
      end
      if (!o_valid) chk("flags_idle", 32'({o_sol, o_eol, o_sof}), 32'd0);
      if (stall_prev) chk("stall_hold", 32'({o_valid, o_sol, o_eol, o_sof, o_pixel}), 32'(prev_out));
      stall_prev = o_valid && !i_ready;
      prev_out   = {o_valid, o_sol, o_eol, o_sof, o_pixel};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic       lv;
    logic       rdy;
    logic       rd;
    logic [AW:0] ad;
    logic       vld;
    logic [7:0] pix;
    logic       sol;
    logic       eol;
    logic       sof;
  } vec_t;

  vec_t tbl [20];
  int   base;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    for (int k = 0; k < 20; k++) begin
      tbl[k] = '{lv: k == 0, rdy: 1'b1, rd: 1'b0, ad: '0, vld: 1'b0, pix: 8'd0,
                 sol: 1'b0, eol: 1'b0, sof: 1'b0};
      if (k == 1) tbl[k].rd = 1'b1;
      if (k == 4 || k == 8 || k == 12) begin
        tbl[k].rd = 1'b1;
        tbl[k].ad = 3'((k - 4) / 4 + 1);
      end
      if (k >= 3 && k <= 18) begin
        tbl[k].vld = 1'b1;
        tbl[k].pix = 8'(k - 3);
        tbl[k].sol = (k == 3);
        tbl[k].sof = (k == 3);
        tbl[k].eol = (k == 18);
      end
    end

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    reset = 1'b0;
    @(negedge pclk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_pixel", 32'(o_pixel), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sol", 32'(o_sol), 32'd0);
    chk("rst_eol", 32'(o_eol), 32'd0);
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();

    // Single line, cycle-exact table
    push_line(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      line_valid = tbl[k].lv;
      i_ready    = tbl[k].rdy;
      @(negedge pclk);
      chk("t1_rd_en", 32'(rd_en), 32'(tbl[k].rd));
      if (tbl[k].rd) chk("t1_addr", 32'(addr), 32'(tbl[k].ad));
      chk("t1_valid", 32'(o_valid), 32'(tbl[k].vld));
      if (tbl[k].vld) begin
        chk("t1_pixel", 32'(o_pixel), 32'(tbl[k].pix));
        chk("t1_flags", 32'({o_sol, o_eol, o_sof}), 32'({tbl[k].sol, tbl[k].eol, tbl[k].sof}));
      end
      tick();
      line_valid = 1'b0;
    end
    chk("t1_queues_empty", 32'(px_q.size() + ad_q.size()), 32'd0);

    // Toggling ready
    do_reset();
    rd_count = 0;
    push_line(1'b0, 1'b1);
    i_ready = 1'b1;
    pulse_lv();
    toggle = 1'b1;
    drain("t2", 300);
    toggle  = 1'b0;
    i_ready = 1'b1;
    chk("t2_rd_pulses", 32'(rd_count), 32'd4);

    // Two lines back to back, ping-pong banks
    do_reset();
    push_line(1'b0, 1'b1);
    push_line(1'b1, 1'b0);
    pulse_lv();
    tick();
    pulse_lv();
    drain("t3", 200);
    chk("t3_line0_span", 32'(acc_cyc[15] - acc_cyc[0]), 32'd15);
    chk("t3_gap", 32'(acc_cyc[16] - acc_cyc[15]), 32'd2);
    chk("t3_line1_span", 32'(acc_cyc[31] - acc_cyc[16]), 32'd15);

    // Frame boundary mid-line
    do_reset();
    push_line(1'b0, 1'b1);
    pulse_lv();
    repeat (8) tick();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    push_line(1'b0, 1'b1);
    pulse_lv();
    drain("t5", 200);

    // Overflow with downstream stalled
    do_reset();
    i_ready = 1'b0;
    base = acc_count;
    push_line(1'b0, 1'b1);
    push_line(1'b1, 1'b0);
    pulse_lv();
    tick();
    pulse_lv();
    chk("t4_ovf_after_2", 32'(overflow), 32'd0);
    tick();
    pulse_lv();
    chk("t4_ovf_after_3", 32'(overflow), 32'd1);
    repeat (5) tick();
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    i_ready = 1'b1;
    drain("t4", 300);
    chk("t4_ovf_end", 32'(overflow), 32'd1);
    chk("t4_pixel_count", 32'(acc_count - base), 32'd32);

    // Reset during word 2 of a line
    base = acc_count;
    push_line(1'b0, 1'b0);
    pulse_lv();
    for (int n = 0; n < 100 && acc_count < base + 9; n++) tick();
    chk("t6_reach_word2", 32'(acc_count >= base + 9), 32'd1);
    do_reset();
    @(negedge pclk);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_rd_en", 32'(rd_en), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    tick();
    push_line(1'b0, 1'b1);
    pulse_lv();
    drain("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
